// File: rtl/garage_door_plant.sv
// Stand-in for a physical garage door: turns motor drive into a stepped position,
// limit switches, a registered beam sensor, crush detection and board status LEDs.
module garage_door_plant #(
    parameter int STEP_CYCLES  = 3_125_000,
    parameter int TRAVEL_STEPS = 16,
    parameter int CRUSH_STEPS  = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       motor_up,
    input  logic       motor_down,
    input  logic       obstruct_sw,
    output logic       limit_open,
    output logic       limit_closed,
    output logic       beam_blocked,
    output logic       fault,
    output logic [4:0] position,
    output logic [2:0] LEDs
);

    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int CW = (CRUSH_STEPS > 1) ? $clog2(CRUSH_STEPS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(STEP_CYCLES - 1);
    localparam logic [4:0]    POS_TOP     = 5'(TRAVEL_STEPS);
    localparam logic [CW-1:0] CRUSH_FINAL = CW'(CRUSH_STEPS - 1);

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_STOPPED = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    pos_q, pos_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] crush_q, crush_d;
    logic          beam_q;
    logic          fault_q;
    logic [2:0]    leds_q;

    logic cmd_up, cmd_dn, cmd_both;
    logic at_top, at_bottom, step_due, moving;

    function automatic logic [2:0] led_code(input state_t s);
        logic [2:0] code;
        case (s)
            ST_OPENING, ST_CLOSING: code = 3'b100;
            ST_OPEN:                code = 3'b010;
            ST_CLOSED:              code = 3'b001;
            ST_STOPPED:             code = 3'b000;
            default:                code = 3'b111;
        endcase
        return code;
    endfunction

    assign cmd_up    = motor_up & ~motor_down;
    assign cmd_dn    = motor_down & ~motor_up;
    assign cmd_both  = motor_up & motor_down;
    assign at_top    = (pos_q == POS_TOP);
    assign at_bottom = (pos_q == 5'd0);
    assign step_due  = (presc_q == PRESC_LAST);
    assign moving    = (state_q == ST_OPENING) || (state_q == ST_CLOSING);

    // Next state and position
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        case (state_q)
            ST_FAULT: begin
                if (!motor_up && !motor_down && !beam_q) begin
                    if (at_bottom)   state_d = ST_CLOSED;
                    else if (at_top) state_d = ST_OPEN;
                    else             state_d = ST_STOPPED;
                end
            end
            ST_CLOSED, ST_OPEN, ST_STOPPED: begin
                if (cmd_both)                   state_d = ST_FAULT;
                else if (cmd_up && !at_top)     state_d = ST_OPENING;
                else if (cmd_dn && !at_bottom)  state_d = ST_CLOSING;
            end
            ST_OPENING: begin
                if (cmd_both) begin
                    state_d = ST_FAULT;
                end else if (cmd_dn) begin
                    state_d = at_bottom ? ST_CLOSED : ST_CLOSING;
                end else if (!cmd_up) begin
                    state_d = ST_STOPPED;
                end else if (step_due) begin
                    if (pos_q >= POS_TOP - 5'd1) begin
                        pos_d   = POS_TOP;
                        state_d = ST_OPEN;
                    end else begin
                        pos_d = pos_q + 5'd1;
                    end
                end
            end
            ST_CLOSING: begin
                if (cmd_both) begin
                    state_d = ST_FAULT;
                end else if (cmd_up) begin
                    state_d = at_top ? ST_OPEN : ST_OPENING;
                end else if (!cmd_dn) begin
                    state_d = ST_STOPPED;
                end else if (step_due) begin
                    pos_d = (pos_q <= 5'd1) ? 5'd0 : pos_q - 5'd1;
                    // A crush takes precedence over landing on the closed limit
                    if (beam_q && (crush_q == CRUSH_FINAL)) state_d = ST_FAULT;
                    else if (pos_q <= 5'd1)                 state_d = ST_CLOSED;
                end
            end
            default: state_d = ST_FAULT;
        endcase
    end

    // Step prescaler and crush counter
    always_comb begin
        presc_d = '0;
        crush_d = '0;
        if (moving && (state_d == state_q)) begin
            presc_d = step_due ? '0 : presc_q + PW'(1);
        end
        if ((state_q == ST_CLOSING) && (state_d == ST_CLOSING) && beam_q) begin
            crush_d = step_due ? crush_q + CW'(1) : crush_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_CLOSED;
            pos_q   <= 5'd0;
            presc_q <= '0;
            crush_q <= '0;
            beam_q  <= 1'b0;
            fault_q <= 1'b0;
            leds_q  <= 3'b001;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            presc_q <= presc_d;
            crush_q <= crush_d;
            beam_q  <= obstruct_sw;
            fault_q <= (state_d == ST_FAULT);
            leds_q  <= led_code(state_d);
        end
    end

    assign position     = pos_q;
    assign limit_open   = at_top;
    assign limit_closed = at_bottom;
    assign beam_blocked = beam_q;
    assign fault        = fault_q;
    assign LEDs         = leds_q;

endmodule

// File: tb/tb_garage_door_plant.sv
// Directed table plus randomized drive for garage_door_plant, checked every cycle
// against a step-counting reference model of the door.
module tb_garage_door_plant;

    localparam int STEP   = 4;
    localparam int TRAVEL = 8;
    localparam int CRUSH  = 2;

    logic       clk = 1'b0;
    logic       rst_n, up, dn, obs;
    logic       lo, lc, beam, flt;
    logic [4:0] pos;
    logic [2:0] leds;

    always #5 clk = ~clk;

    garage_door_plant #(
        .STEP_CYCLES (STEP),
        .TRAVEL_STEPS(TRAVEL),
        .CRUSH_STEPS (CRUSH)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .motor_up    (up),
        .motor_down  (dn),
        .obstruct_sw (obs),
        .limit_open  (lo),
        .limit_closed(lc),
        .beam_blocked(beam),
        .fault       (flt),
        .position    (pos),
        .LEDs        (leds)
    );

    localparam int M_CLOSED = 0, M_OPENING = 1, M_OPEN = 2, M_CLOSING = 3, M_STOPPED = 4, M_FAULT = 5;

    int m_mode = M_CLOSED;
    int m_pos = 0;
    int m_elapsed = 0;
    int m_blocked_steps = 0;
    bit m_beam = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int model_leds(input int mode);
        case (mode)
            M_OPENING, M_CLOSING: return 3'b100;
            M_OPEN:               return 3'b010;
            M_CLOSED:             return 3'b001;
            M_STOPPED:            return 3'b000;
            default:              return 3'b111;
        endcase
    endfunction

    // Door behaviour at one clock edge, from the inputs present before that edge
    task automatic model_edge(input bit r, input bit u, input bit d, input bit o);
        bit beam_now;
        int prev;
        beam_now = m_beam;
        prev     = m_mode;
        m_beam   = o;
        if (!r) begin
            m_mode = M_CLOSED; m_pos = 0; m_elapsed = 0; m_blocked_steps = 0; m_beam = 1'b0;
            return;
        end
        if (m_mode == M_FAULT) begin
            if (!u && !d && !beam_now)
                m_mode = (m_pos == 0) ? M_CLOSED : (m_pos == TRAVEL) ? M_OPEN : M_STOPPED;
        end else if (u && d) begin
            m_mode = M_FAULT;
        end else begin
            case (m_mode)
                M_OPENING: begin
                    if (d)       m_mode = (m_pos > 0) ? M_CLOSING : M_CLOSED;
                    else if (!u) m_mode = M_STOPPED;
                    else begin
                        m_elapsed++;
                        if (m_elapsed == STEP) begin
                            m_elapsed = 0;
                            m_pos = (m_pos + 1 > TRAVEL) ? TRAVEL : m_pos + 1;
                            if (m_pos == TRAVEL) m_mode = M_OPEN;
                        end
                    end
                end
                M_CLOSING: begin
                    if (u)       m_mode = (m_pos < TRAVEL) ? M_OPENING : M_OPEN;
                    else if (!d) m_mode = M_STOPPED;
                    else begin
                        m_elapsed++;
                        if (m_elapsed == STEP) begin
                            m_elapsed = 0;
                            m_pos = (m_pos - 1 < 0) ? 0 : m_pos - 1;
                            if (beam_now) m_blocked_steps++;
                            if (m_blocked_steps == CRUSH) m_mode = M_FAULT;
                            else if (m_pos == 0)          m_mode = M_CLOSED;
                        end
                    end
                end
                default: begin
                    if (u && m_pos < TRAVEL)  m_mode = M_OPENING;
                    else if (d && m_pos > 0)  m_mode = M_CLOSING;
                end
            endcase
        end
        if (m_mode != prev) m_elapsed = 0;
        if (m_mode != M_CLOSING || !beam_now) m_blocked_steps = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model.position", int'(pos), m_pos);
        chk("model.leds", int'(leds), model_leds(m_mode));
        chk("model.fault", int'(flt), (m_mode == M_FAULT) ? 1 : 0);
        chk("model.limit_open", int'(lo), (m_pos == TRAVEL) ? 1 : 0);
        chk("model.limit_closed", int'(lc), (m_pos == 0) ? 1 : 0);
        chk("model.beam", int'(beam), int'(m_beam));
    endtask

    task automatic tick(input bit r, input bit u, input bit d, input bit o);
        rst_n = r; up = u; dn = d; obs = o;
        @(posedge clk);
        model_edge(r, u, d, o);
        #1;
        check_model();
    endtask

    typedef struct packed {
        logic       r, u, d, o;
        logic [7:0] n;
        logic [4:0] pos;
        logic [2:0] leds;
        logic       flt, lo, lc, beam;
    } vec_t;

    function automatic vec_t mkv(input bit r, input bit u, input bit d, input bit o, input int n,
                                 input int p, input logic [2:0] l, input bit f, input bit o_lim,
                                 input bit c_lim, input bit b);
        vec_t v;
        v.r = r; v.u = u; v.d = d; v.o = o; v.n = 8'(n);
        v.pos = 5'(p); v.leds = l; v.flt = f; v.lo = o_lim; v.lc = c_lim; v.beam = b;
        return v;
    endfunction

    localparam int NV = 25;
    vec_t tbl [NV];

    initial begin
        rst_n = 1'b0; up = 1'b0; dn = 1'b0; obs = 1'b0;

        //            rst u  d  o   n    pos leds    flt lo lc beam
        tbl[0]  = mkv(0, 0, 0, 0,  2,   0, 3'b001, 0, 0, 1, 0);
        tbl[1]  = mkv(1, 1, 0, 0, 32,   7, 3'b100, 0, 0, 0, 0);
        tbl[2]  = mkv(1, 1, 0, 0,  1,   8, 3'b010, 0, 1, 0, 0);
        tbl[3]  = mkv(1, 1, 0, 0,  5,   8, 3'b010, 0, 1, 0, 0);
        tbl[4]  = mkv(1, 0, 1, 0, 12,   6, 3'b100, 0, 0, 0, 0);
        tbl[5]  = mkv(1, 0, 1, 0,  1,   5, 3'b100, 0, 0, 0, 0);
        tbl[6]  = mkv(1, 0, 0, 0,  1,   5, 3'b000, 0, 0, 0, 0);
        tbl[7]  = mkv(1, 1, 0, 0,  5,   6, 3'b100, 0, 0, 0, 0);
        tbl[8]  = mkv(1, 0, 1, 1,  1,   6, 3'b100, 0, 0, 0, 1);
        tbl[9]  = mkv(1, 0, 1, 1,  4,   5, 3'b100, 0, 0, 0, 1);
        tbl[10] = mkv(1, 0, 1, 1,  4,   4, 3'b111, 1, 0, 0, 1);
        tbl[11] = mkv(1, 0, 1, 1,  3,   4, 3'b111, 1, 0, 0, 1);
        tbl[12] = mkv(1, 0, 0, 0,  1,   4, 3'b111, 1, 0, 0, 0);
        tbl[13] = mkv(1, 0, 0, 0,  1,   4, 3'b000, 0, 0, 0, 0);
        tbl[14] = mkv(1, 0, 1, 0, 17,   0, 3'b001, 0, 0, 1, 0);
        tbl[15] = mkv(1, 0, 1, 0,  3,   0, 3'b001, 0, 0, 1, 0);
        tbl[16] = mkv(1, 1, 1, 0,  1,   0, 3'b111, 1, 0, 1, 0);
        tbl[17] = mkv(1, 1, 1, 0,  2,   0, 3'b111, 1, 0, 1, 0);
        tbl[18] = mkv(1, 0, 0, 0,  1,   0, 3'b001, 0, 0, 1, 0);
        tbl[19] = mkv(1, 1, 0, 0, 16,   3, 3'b100, 0, 0, 0, 0);
        tbl[20] = mkv(1, 0, 1, 0,  4,   3, 3'b100, 0, 0, 0, 0);
        tbl[21] = mkv(1, 0, 1, 0,  1,   2, 3'b100, 0, 0, 0, 0);
        tbl[22] = mkv(1, 1, 0, 0, 13,   5, 3'b100, 0, 0, 0, 0);
        tbl[23] = mkv(0, 1, 0, 0,  1,   0, 3'b001, 0, 0, 1, 0);
        tbl[24] = mkv(1, 0, 0, 0,  1,   0, 3'b001, 0, 0, 1, 0);

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < int'(tbl[i].n); k++)
                tick(tbl[i].r, tbl[i].u, tbl[i].d, tbl[i].o);
            chk($sformatf("vec%0d.position", i), int'(pos), int'(tbl[i].pos));
            chk($sformatf("vec%0d.leds", i), int'(leds), int'(tbl[i].leds));
            chk($sformatf("vec%0d.fault", i), int'(flt), int'(tbl[i].flt));
            chk($sformatf("vec%0d.limit_open", i), int'(lo), int'(tbl[i].lo));
            chk($sformatf("vec%0d.limit_closed", i), int'(lc), int'(tbl[i].lc));
            chk($sformatf("vec%0d.beam", i), int'(beam), int'(tbl[i].beam));
            $display("vec %0d: rst_n=%0b up=%0b dn=%0b obs=%0b x%0d -> pos=%0d leds=%b fault=%0b lo=%0b lc=%0b beam=%0b",
                     i, tbl[i].r, tbl[i].u, tbl[i].d, tbl[i].o, tbl[i].n, pos, leds, flt, lo, lc, beam);
        end

        // Randomized bursts of held drive, checked cycle by cycle against the model
        for (int b = 0; b < 250; b++) begin
            int sel, len;
            bit r, u, d, o;
            sel = int'($urandom_range(0, 99));
            len = int'($urandom_range(1, 40));
            r = 1'b1; u = 1'b0; d = 1'b0;
            if (sel < 40)      u = 1'b1;
            else if (sel < 80) d = 1'b1;
            else if (sel < 90) begin end
            else if (sel < 96) begin u = 1'b1; d = 1'b1; len = 2; end
            else begin r = 1'b0; len = 1; end
            o = ($urandom_range(0, 99) < 20);
            for (int k = 0; k < len; k++) tick(r, u, d, o);
            $display("rand %0d: rst_n=%0b up=%0b dn=%0b obs=%0b x%0d -> pos=%0d leds=%b fault=%0b",
                     b, r, u, d, o, len, pos, leds, flt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
